// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM command/data pins among init, refresh, write and read sub-controllers.
// Optional macro ARB_FAIR_EN alternates write/read when both are pending.
module sdram_arbiter #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        sys_clk_i,
   input  logic        rst_i,
   input  logic        init_end_i,
   input  logic [3:0]  init_cmd_i,
   input  logic [1:0]  init_ba_i,
   input  logic [12:0] init_addr_i,
   input  logic        aref_req_i,
   input  logic        aref_end_i,
   input  logic [3:0]  aref_cmd_i,
   input  logic [1:0]  aref_ba_i,
   input  logic [12:0] aref_addr_i,
   input  logic        wr_req_i,
   input  logic        wr_end_i,
   input  logic [3:0]  write_cmd_i,
   input  logic [1:0]  write_ba_i,
   input  logic [12:0] write_addr_i,
   input  logic        wr_sdram_en_i,
   input  logic [15:0] wr_sdram_data_i,
   input  logic        rd_req_i,
   input  logic        rd_end_i,
   input  logic [3:0]  read_cmd_i,
   input  logic [1:0]  read_ba_i,
   input  logic [12:0] read_addr_i,
   output logic        aref_en_o,
   output logic        wr_en_o,
   output logic        rd_en_o,
   output logic        arb_err_o,
   output logic        sdram_cke_o,
   output logic        sdram_cs_n_o,
   output logic        sdram_ras_n_o,
   output logic        sdram_cas_n_o,
   output logic        sdram_we_n_o,
   output logic [1:0]  sdram_ba_o,
   output logic [12:0] sdram_addr_o,
   output logic [15:0] sdram_dq_o,
   output logic        sdram_dq_oe_o
);
   typedef enum logic [2:0] {ARB_INIT, ARB_ARBIT, ARB_AREF, ARB_WRITE, ARB_READ} state_t;
   state_t      r_state, w_next;
   logic [9:0]  r_cnt;
   logic        r_err;
   logic [3:0]  r_cmd, w_cmd;
   logic [1:0]  r_ba, w_ba;
   logic [12:0] r_addr, w_addr;
   logic [15:0] r_dq;
   logic        r_oe, w_oe;
   logic        w_grant, w_end, w_to, w_wr_first;
`ifdef ARB_FAIR_EN
   logic        r_last_rd;
   assign w_wr_first = r_last_rd;
`else
   assign w_wr_first = 1'b1;
`endif
   always_comb begin
      w_grant = (r_state == ARB_AREF) || (r_state == ARB_WRITE) || (r_state == ARB_READ);
      w_end   = (r_state == ARB_AREF && aref_end_i) || (r_state == ARB_WRITE && wr_end_i) ||
                (r_state == ARB_READ && rd_end_i);
      w_to    = w_grant && !w_end && (r_cnt == 10'(TIMEOUT_CYCLES - 1));
      w_next  = r_state;
      case (r_state)
         ARB_INIT:  w_next = init_end_i ? ARB_ARBIT : ARB_INIT;
         ARB_ARBIT: w_next = aref_req_i ? ARB_AREF :
                             (wr_req_i && rd_req_i) ? (w_wr_first ? ARB_WRITE : ARB_READ) :
                             wr_req_i ? ARB_WRITE : rd_req_i ? ARB_READ : ARB_ARBIT;
         default:   w_next = (w_end || w_to) ? ARB_ARBIT : r_state;
      endcase
      w_cmd  = 4'b0111;
      w_ba   = 2'b11;
      w_addr = 13'h1FFF;
      case (r_state)
         ARB_INIT:  {w_cmd, w_ba, w_addr} = {init_cmd_i, init_ba_i, init_addr_i};
         ARB_AREF:  {w_cmd, w_ba, w_addr} = {aref_cmd_i, aref_ba_i, aref_addr_i};
         ARB_WRITE: {w_cmd, w_ba, w_addr} = {write_cmd_i, write_ba_i, write_addr_i};
         ARB_READ:  {w_cmd, w_ba, w_addr} = {read_cmd_i, read_ba_i, read_addr_i};
         default:   ;
      endcase
      // a timed-out owner may be mid-burst; its command is replaced by a NOP
      if (w_to) {w_cmd, w_ba, w_addr} = {4'b0111, 2'b11, 13'h1FFF};
      w_oe = (r_state == ARB_WRITE) && wr_sdram_en_i && !w_to;
   end
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         r_state <= ARB_INIT;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_cmd   <= 4'b0111;
         r_ba    <= 2'b11;
         r_addr  <= 13'h1FFF;
         r_dq    <= '0;
         r_oe    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_grant && !w_end && !w_to) ? r_cnt + 10'd1 : '0;
         r_err   <= w_to;
         r_cmd   <= w_cmd;
         r_ba    <= w_ba;
         r_addr  <= w_addr;
         r_dq    <= w_oe ? wr_sdram_data_i : 16'h0000;
         r_oe    <= w_oe;
      end
   end
`ifdef ARB_FAIR_EN
   always_ff @(posedge sys_clk_i) begin
      if (rst_i) r_last_rd <= 1'b1;
      else if (r_state == ARB_ARBIT && w_next == ARB_WRITE) r_last_rd <= 1'b0;
      else if (r_state == ARB_ARBIT && w_next == ARB_READ) r_last_rd <= 1'b1;
   end
`endif
   assign aref_en_o     = (r_state == ARB_AREF);
   assign wr_en_o       = (r_state == ARB_WRITE);
   assign rd_en_o       = (r_state == ARB_READ);
   assign arb_err_o     = r_err;
   assign sdram_cke_o   = 1'b1;
   assign {sdram_cs_n_o, sdram_ras_n_o, sdram_cas_n_o, sdram_we_n_o} = r_cmd;
   assign sdram_ba_o    = r_ba;
   assign sdram_addr_o  = r_addr;
   assign sdram_dq_o    = r_dq;
   assign sdram_dq_oe_o = r_oe;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: random requesters checked against a queue-fed owner/age model of the arbiter.
module tb_sdram_arbiter;
   localparam int TO = 16;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, init_end;
   logic [3:0]  init_cmd, aref_cmd, write_cmd, read_cmd;
   logic [1:0]  init_ba, aref_ba, write_ba, read_ba;
   logic [12:0] init_addr, aref_addr, write_addr, read_addr;
   logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
   logic [15:0] wr_data;
   logic        aref_en, wr_en, rd_en, arb_err, cke, cs_n, ras_n, cas_n, we_n, dq_oe;
   logic [1:0]  ba;
   logic [12:0] addr;
   logic [15:0] dq;
   sdram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .sys_clk_i(clk), .rst_i(rst), .init_end_i(init_end),
      .init_cmd_i(init_cmd), .init_ba_i(init_ba), .init_addr_i(init_addr),
      .aref_req_i(aref_req), .aref_end_i(aref_end),
      .aref_cmd_i(aref_cmd), .aref_ba_i(aref_ba), .aref_addr_i(aref_addr),
      .wr_req_i(wr_req), .wr_end_i(wr_end),
      .write_cmd_i(write_cmd), .write_ba_i(write_ba), .write_addr_i(write_addr),
      .wr_sdram_en_i(wr_sdram_en), .wr_sdram_data_i(wr_data),
      .rd_req_i(rd_req), .rd_end_i(rd_end),
      .read_cmd_i(read_cmd), .read_ba_i(read_ba), .read_addr_i(read_addr),
      .aref_en_o(aref_en), .wr_en_o(wr_en), .rd_en_o(rd_en), .arb_err_o(arb_err),
      .sdram_cke_o(cke), .sdram_cs_n_o(cs_n), .sdram_ras_n_o(ras_n), .sdram_cas_n_o(cas_n),
      .sdram_we_n_o(we_n), .sdram_ba_o(ba), .sdram_addr_o(addr),
      .sdram_dq_o(dq), .sdram_dq_oe_o(dq_oe));
   // {aref_en, wr_en, rd_en, err, cke, cmd[3:0], ba, addr, dq, oe}
   logic [40:0] sb[$];
   logic [40:0] act;
   assign act = {aref_en, wr_en, rd_en, arb_err, cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq, dq_oe};
   int tests = 0, fails = 0, cyc = 0;
   // model: owner 0 = none, 1 = refresh, 2 = write, 3 = read; age = grant cycles already served
   bit m_init_done;
   int m_owner, m_age, since_rst;
   bit m_last_rd;
   task automatic model_step();
      logic [3:0] c; logic [1:0] b; logic [12:0] a; logic [15:0] d; logic oe, to, own_end;
      if (rst) begin
         m_init_done = 0; m_owner = 0; m_age = 0; m_last_rd = 1;
         sb.push_back({3'b000, 1'b0, 1'b1, 4'b0111, 2'b11, 13'h1FFF, 16'h0000, 1'b0});
         return;
      end
      own_end = (m_owner == 1 && aref_end) || (m_owner == 2 && wr_end) || (m_owner == 3 && rd_end);
      to = m_owner != 0 && !own_end && m_age + 1 == TO;
      {c, b, a} = {4'b0111, 2'b11, 13'h1FFF};
      if (!m_init_done) {c, b, a} = {init_cmd, init_ba, init_addr};
      else if (m_owner == 1) {c, b, a} = {aref_cmd, aref_ba, aref_addr};
      else if (m_owner == 2) {c, b, a} = {write_cmd, write_ba, write_addr};
      else if (m_owner == 3) {c, b, a} = {read_cmd, read_ba, read_addr};
      if (to) {c, b, a} = {4'b0111, 2'b11, 13'h1FFF};
      oe = m_owner == 2 && wr_sdram_en && !to;
      d = oe ? wr_data : 16'h0000;
      if (!m_init_done) m_init_done = init_end;
      else if (m_owner == 0) begin
         m_age = 0;
         if (aref_req) m_owner = 1;
`ifdef ARB_FAIR_EN
         else if (wr_req && rd_req) m_owner = m_last_rd ? 2 : 3;
`else
         else if (wr_req && rd_req) m_owner = 2;
`endif
         else if (wr_req) m_owner = 2;
         else if (rd_req) m_owner = 3;
         if (m_owner == 2) m_last_rd = 0;
         if (m_owner == 3) m_last_rd = 1;
      end else if (own_end || to) begin
         m_owner = 0; m_age = 0;
      end else m_age++;
      sb.push_back({m_owner == 1, m_owner == 2, m_owner == 3, to, 1'b1, c, b, a, d, oe});
   endtask
   always @(posedge clk) begin
      logic [40:0] e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (act !== e) begin
            fails++;
            $display("FAIL cycle %0d pins: got %h expected %h", cyc, act, e);
         end
      end
   end
   initial begin
      {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} = '0;
      {init_cmd, init_ba, init_addr, aref_cmd, aref_ba, aref_addr} = '0;
      {write_cmd, write_ba, write_addr, read_cmd, read_ba, read_addr, wr_data} = '0;
      rst = 1'b1;
      since_rst = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         cyc = i;
         rst = (i < 3) || ($urandom % 400 == 0);
         since_rst = rst ? 0 : since_rst + 1;
         init_end = since_rst >= 10 ? ($urandom % 4 != 0) : 1'b0;
         {init_cmd, init_ba, init_addr} = 19'($urandom);
         {aref_cmd, aref_ba, aref_addr} = 19'($urandom);
         {write_cmd, write_ba, write_addr} = 19'($urandom);
         {read_cmd, read_ba, read_addr} = 19'($urandom);
         if (i % 7 == 0) write_cmd = 4'b0100;
         wr_sdram_en = $urandom % 3 != 0;
         wr_data = (i % 5 == 0) ? 16'hA5A5 : 16'($urandom);
         // requesters hold until they own the bus, then drop
         aref_req = m_owner == 1 ? 1'b0 : (aref_req || $urandom % 40 == 0);
         wr_req   = m_owner == 2 ? 1'b0 : (wr_req || $urandom % 4 == 0);
         rd_req   = m_owner == 3 ? 1'b0 : (rd_req || $urandom % 4 == 0);
         aref_end = (m_owner == 1) ? ($urandom % 6 == 0) : ($urandom % 20 == 0);
         wr_end   = (m_owner == 2) ? ($urandom % 12 == 0) : ($urandom % 20 == 0);
         rd_end   = (m_owner == 3) ? ($urandom % 12 == 0) : ($urandom % 20 == 0);
         model_step();
      end
      @(posedge clk);
      #2;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d queued expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
